// File: rtl/memory_bus_arbiter.sv
// Shared-memory arbiter: merges two instruction and two data request streams onto one RAM port,
// holding the grant across a cache block and sourcing cache-to-cache forwarded data.
module memory_bus_arbiter #(
    parameter int unsigned BLOCK_WORDS = 2,
    parameter int unsigned WORD_W      = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    input  logic                   c2c,
    input  logic [1:0][WORD_W-1:0] fwd_data,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t           r_state, w_next_state;
    logic             r_core, w_next_core;
    logic             r_rr, w_next_rr;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;

    logic [1:0] w_dreq;
    logic       w_owner_req;
    logic       w_done;

    assign w_dreq = dREN | dWEN;
    assign w_done = w_owner_req && (ramstate == RAM_ACCESS);

    always_comb begin
        w_owner_req = 1'b0;
        case (r_state)
            DGRANT:  w_owner_req = w_dreq[r_core];
            IGRANT:  w_owner_req = iREN[r_core];
            default: w_owner_req = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_core  <= 1'b0;
            r_rr    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_core  <= w_next_core;
            r_rr    <= w_next_rr;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_core  = r_core;
        w_next_rr    = r_rr;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|w_dreq) begin
                    w_next_state = DGRANT;
                    w_next_core  = (w_dreq == 2'b11) ? r_rr : w_dreq[1];
                end else if (|iREN) begin
                    w_next_state = IGRANT;
                    w_next_core  = (iREN == 2'b11) ? r_rr : iREN[1];
                end
            end
            default: begin
                if (!w_owner_req) begin
                    // A drop after a completed word ends the block; a drop before any word is an abort.
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                    if (r_cnt != '0) begin
                        w_next_rr = ~r_core;
                    end
                end else if (w_done) begin
                    if (32'(r_cnt) + 32'd1 < BLOCK_WORDS) begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end else begin
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                        w_next_rr    = ~r_core;
                    end
                end
            end
        endcase
    end

    always_comb begin
        iwait    = 2'b11;
        dwait    = 2'b11;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (w_owner_req) begin
            case (r_state)
                DGRANT: begin
                    ramaddr = daddr[r_core];
                    if (dWEN[r_core]) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore[r_core];
                    end else if (c2c) begin
                        // Snoop hit on a modified line: flush the peer's data and hand it to the reader.
                        ramWEN   = 1'b1;
                        ramstore = fwd_data[r_core];
                        if (w_done) begin
                            dload[r_core] = fwd_data[r_core];
                        end
                    end else begin
                        ramREN = 1'b1;
                        if (w_done) begin
                            dload[r_core] = ramload;
                        end
                    end
                    if (w_done) begin
                        dwait[r_core] = 1'b0;
                    end
                end
                IGRANT: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[r_core];
                    if (w_done) begin
                        iload[r_core] = ramload;
                        iwait[r_core] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_memory_bus_arbiter;

    localparam int unsigned BW = 2;
    localparam int unsigned W  = 32;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [1:0]        iREN, dREN, dWEN, iwait, dwait, ramstate;
    logic [1:0][W-1:0] iaddr, iload, daddr, dstore, dload, fwd_data;
    logic              c2c, ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore, ramload;

    memory_bus_arbiter #(.BLOCK_WORDS(BW), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .c2c(c2c), .fwd_data(fwd_data),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    // Reference model: owner class (0 none, 1 data, 2 instr), owner core, words done, rr pointer.
    int m_cls, m_core, m_cnt, m_rr;
    int last_done;
    int log_q[$];
    int rem_d[2];
    int rem_i[2];
    bit auto_en, rand_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int rr);
        if (req == 2'b11) return rr;
        return req[1] ? 1 : 0;
    endfunction

    function automatic bit owner_req();
        if (m_cls == 1) return dREN[m_core] | dWEN[m_core];
        if (m_cls == 2) return iREN[m_core];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cls = 0; m_core = 0; m_cnt = 0; m_rr = 0; last_done = -1;
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0]        e_iwait, e_dwait;
        logic [1:0][W-1:0] e_iload, e_dload;
        logic              e_ren, e_wen;
        logic [W-1:0]      e_addr, e_store;
        bit act, done;
        e_iwait = 2'b11; e_dwait = 2'b11; e_iload = '0; e_dload = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        act  = owner_req();
        done = act && (ramstate == 2'd2);
        if (act && m_cls == 1) begin
            e_addr = daddr[m_core];
            if (dWEN[m_core]) begin
                e_wen = 1'b1; e_store = dstore[m_core];
            end else if (c2c) begin
                e_wen = 1'b1; e_store = fwd_data[m_core];
                if (done) e_dload[m_core] = fwd_data[m_core];
            end else begin
                e_ren = 1'b1;
                if (done) e_dload[m_core] = ramload;
            end
            if (done) e_dwait[m_core] = 1'b0;
        end else if (act && m_cls == 2) begin
            e_ren = 1'b1; e_addr = iaddr[m_core];
            if (done) begin
                e_iload[m_core] = ramload; e_iwait[m_core] = 1'b0;
            end
        end
        last_done = done ? m_cls * 4 + m_core : -1;
        chk({tag, ".iwait"}, 64'(iwait), 64'(e_iwait));
        chk({tag, ".dwait"}, 64'(dwait), 64'(e_dwait));
        chk({tag, ".iload"}, 64'(iload), 64'(e_iload));
        chk({tag, ".dload"}, 64'(dload), 64'(e_dload));
        chk({tag, ".ramREN"}, 64'(ramREN), 64'(e_ren));
        chk({tag, ".ramWEN"}, 64'(ramWEN), 64'(e_wen));
        chk({tag, ".ramaddr"}, 64'(ramaddr), 64'(e_addr));
        chk({tag, ".ramstore"}, 64'(ramstore), 64'(e_store));
    endtask

    task automatic model_step();
        bit act, done;
        act  = owner_req();
        done = act && (ramstate == 2'd2);
        if (m_cls == 0) begin
            if ((dREN | dWEN) != 2'b00) begin
                m_cls = 1; m_core = pick(dREN | dWEN, m_rr);
            end else if (iREN != 2'b00) begin
                m_cls = 2; m_core = pick(iREN, m_rr);
            end
        end else if (!act) begin
            if (m_cnt > 0) m_rr = 1 - m_core;
            m_cls = 0; m_cnt = 0;
        end else if (done) begin
            m_cnt++;
            if (m_cnt >= int'(BW)) begin
                m_cls = 0; m_cnt = 0; m_rr = 1 - m_core;
            end
        end
    endtask

    task automatic drive_auto();
        int c;
        int kind;
        if (last_done >= 0) begin
            c = last_done % 4;
            if (last_done / 4 == 1) begin
                rem_d[c]--; daddr[c] = daddr[c] + 4; dstore[c] = $urandom;
                if (rem_d[c] == 0) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
            end else begin
                rem_i[c]--; iaddr[c] = iaddr[c] + 4;
                if (rem_i[c] == 0) iREN[c] = 1'b0;
            end
        end
        if (rand_en) begin
            for (int k = 0; k < 2; k++) begin
                if (rem_d[k] == 0 && $urandom_range(0, 3) == 0) begin
                    rem_d[k] = BW; kind = $urandom_range(0, 2);
                    dREN[k] = (kind != 1); dWEN[k] = (kind != 0);
                    daddr[k] = $urandom & 32'hFFFF_FFFC; dstore[k] = $urandom;
                end
                if (rem_i[k] == 0 && $urandom_range(0, 3) == 0) begin
                    rem_i[k] = BW; iREN[k] = 1'b1; iaddr[k] = $urandom & 32'hFFFF_FFFC;
                end
            end
            ramstate = 2'($urandom_range(0, 3));
            ramload = $urandom; c2c = 1'($urandom_range(0, 1));
            fwd_data[0] = $urandom; fwd_data[1] = $urandom;
        end else begin
            ramstate = (ramstate == 2'd2) ? 2'd1 : 2'd2;
            ramload = $urandom;
        end
    endtask

    // Checks the current cycle, records DUT-observed completions, then advances one clock.
    task automatic cycle(input string tag);
        check_outputs(tag);
        for (int k = 0; k < 2; k++) begin
            if (dwait[k] == 1'b0) log_q.push_back(4 + k);
            if (iwait[k] == 1'b0) log_q.push_back(8 + k);
        end
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        if (auto_en) drive_auto();
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
        c2c = 1'b0; fwd_data = '0; ramload = '0; ramstate = 2'd0;
        rem_d = '{0, 0}; rem_i = '{0, 0}; auto_en = 1'b0; rand_en = 1'b0;
        log_q.delete();
    endtask

    task automatic apply_reset(input string tag);
        nRST = 1'b0;
        #1;
        chk({tag, ".iwait"}, 64'(iwait), 64'(2'b11));
        chk({tag, ".dwait"}, 64'(dwait), 64'(2'b11));
        chk({tag, ".ren"}, 64'(ramREN), 64'(1'b0));
        chk({tag, ".wen"}, 64'(ramWEN), 64'(1'b0));
        chk({tag, ".addr"}, 64'(ramaddr), 64'(0));
        chk({tag, ".store"}, 64'(ramstore), 64'(0));
        chk({tag, ".loads"}, 64'(iload) | 64'(dload), 64'(0));
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    int t2_exp[6] = '{4, 4, 5, 5, 8, 8};
    int t3_exp[3] = '{4, 4, 5};
    int t_wen, t_done;

    initial begin
        clear_inputs();
        model_reset();
        @(negedge CLK);
        apply_reset("rst");

        // Single read with three BUSY cycles.
        dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = 2'd1; #1;
        chk("t1.idle_ren", 64'(ramREN), 64'(1'b0));
        cycle("t1");
        chk("t1.ren", 64'(ramREN), 64'(1'b1));
        chk("t1.addr", 64'(ramaddr), 64'h100);
        chk("t1.busy_wait", 64'(dwait), 64'(2'b11));
        cycle("t1"); cycle("t1"); cycle("t1");
        ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
        chk("t1.access_wait", 64'(dwait), 64'(2'b10));
        chk("t1.dload", 64'(dload[0]), 64'hDEADBEEF);
        cycle("t1");
        dREN[0] = 1'b0; ramstate = 2'd0; #1;
        chk("t1.after_dload", 64'(dload[0]), 64'(0));
        cycle("t1"); cycle("t1");
        chk("t1.idle_after", 64'(ramREN), 64'(1'b0));

        // Priority and fairness.
        clear_inputs(); apply_reset("t2rst");
        iREN[0] = 1'b1; dREN = 2'b11; daddr[0] = 32'h1000; daddr[1] = 32'h2000;
        iaddr[0] = 32'h3000; rem_d = '{2, 2}; rem_i[0] = 2; ramstate = 2'd1; auto_en = 1'b1; #1;
        for (int n = 0; n < 60 && (dREN | dWEN | iREN) != 2'b00; n++) cycle("t2");
        chk("t2.count", 64'(log_q.size()), 64'(6));
        for (int i = 0; i < 6; i++) if (i < log_q.size()) chk("t2.order", 64'(log_q[i]), 64'(t2_exp[i]));

        // Block lock: core1 write must wait for both core0 words plus one idle cycle.
        clear_inputs(); apply_reset("t3rst");
        dREN[0] = 1'b1; daddr[0] = 32'h200; dWEN[1] = 1'b1; daddr[1] = 32'h500;
        dstore[1] = 32'h5555AAAA; rem_d = '{2, 1}; ramstate = 2'd1; auto_en = 1'b1; #1;
        t_wen = -1; t_done = -1;
        for (int n = 0; n < 60 && (dREN | dWEN) != 2'b00; n++) begin
            if (ramWEN && t_wen < 0) t_wen = n;
            if (dwait[0] == 1'b0) t_done = n;
            cycle("t3");
        end
        chk("t3.gap", 64'(t_wen - t_done), 64'(2));
        chk("t3.count", 64'(log_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) if (i < log_q.size()) chk("t3.order", 64'(log_q[i]), 64'(t3_exp[i]));

        // Cache-to-cache forward with flush.
        clear_inputs(); apply_reset("t4rst");
        dREN[1] = 1'b1; c2c = 1'b1; fwd_data[1] = 32'h12345678; daddr[1] = 32'h300;
        ramload = 32'hAAAA5555; ramstate = 2'd1; #1;
        cycle("t4");
        chk("t4.wen", 64'(ramWEN), 64'(1'b1));
        chk("t4.ren", 64'(ramREN), 64'(1'b0));
        chk("t4.store", 64'(ramstore), 64'h12345678);
        chk("t4.addr", 64'(ramaddr), 64'h300);
        cycle("t4");
        ramstate = 2'd2; #1;
        chk("t4.dload", 64'(dload[1]), 64'h12345678);
        chk("t4.dwait", 64'(dwait), 64'(2'b01));
        chk("t4.ren_acc", 64'(ramREN), 64'(1'b0));
        cycle("t4");
        dREN[1] = 1'b0; c2c = 1'b0; ramstate = 2'd0; #1;
        cycle("t4"); cycle("t4");

        // Abort before completion leaves the rr pointer alone.
        clear_inputs(); apply_reset("t5rst");
        dREN[0] = 1'b1; daddr[0] = 32'h600; ramstate = 2'd1; #1;
        cycle("t5");
        chk("t5.ren", 64'(ramREN), 64'(1'b1));
        cycle("t5");
        dREN[0] = 1'b0; #1;
        cycle("t5");
        chk("t5.ren_off", 64'(ramREN), 64'(1'b0));
        chk("t5.dwait", 64'(dwait), 64'(2'b11));
        cycle("t5");
        dREN = 2'b11; daddr[1] = 32'h700; #1;
        cycle("t5");
        chk("t5.rr_kept", 64'(ramaddr), 64'h600);
        dREN = 2'b00; #1;
        cycle("t5"); cycle("t5");

        // Reset in the middle of a write.
        clear_inputs(); apply_reset("t6rst");
        dREN[0] = 1'b1; daddr[0] = 32'h800; dWEN[1] = 1'b1; daddr[1] = 32'h900;
        dstore[1] = 32'h0000CAFE; ramstate = 2'd2; #1;
        cycle("t6");
        chk("t6.first", 64'(ramaddr), 64'h800);
        cycle("t6");
        dREN[0] = 1'b0; ramstate = 2'd1; #1;
        cycle("t6"); cycle("t6");
        chk("t6.wen", 64'(ramWEN), 64'(1'b1));
        chk("t6.waddr", 64'(ramaddr), 64'h900);
        cycle("t6");
        apply_reset("t6mid");
        dREN[0] = 1'b1; #1;
        cycle("t6");
        chk("t6.rearb_addr", 64'(ramaddr), 64'h800);
        chk("t6.rearb_ren", 64'(ramREN), 64'(1'b1));
        chk("t6.rearb_wen", 64'(ramWEN), 64'(1'b0));

        // Randomized traffic against the reference model.
        clear_inputs(); apply_reset("rndrst");
        auto_en = 1'b1; rand_en = 1'b1; #1;
        for (int n = 0; n < 3000; n++) cycle("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shared-memory arbiter sitting directly downstream of the dual-core coherence controller.
- Merges 2 instruction-fetch and 2 data request streams onto the single RAM port.
- Sources forwarded cache-to-cache data when the coherence controller signals a snoop hit on a modified line, and writes that data back to RAM in the same transaction.
- Holds a grant across the words of one cache block so each block transfer is atomic on the bus.

Parameters:
- BLOCK_WORDS, 2, words per cache block; grant is held for up to this many consecutive completed words from one requester.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  2  per-core instruction read request.
- iaddr  in  2xWORD_W  per-core instruction address.
- iwait  out  2  per-core instruction wait; 0 = iload valid this cycle.
- iload  out  2xWORD_W  per-core instruction data.
- dREN  in  2  per-core data read request.
- dWEN  in  2  per-core data write request.
- daddr  in  2xWORD_W  per-core data address.
- dstore  in  2xWORD_W  per-core write data.
- dwait  out  2  per-core data wait; 0 = access completes this cycle.
- dload  out  2xWORD_W  per-core read data.
- c2c  in  1  coherence controller: current data read is serviced by the other cache.
- fwd_data  in  2xWORD_W  forwarded word destined for core k (index = reader).
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (word done this cycle), 3 ERROR.

Behaviour:
- Reset: state IDLE; rr_ptr=0; word_cnt=0; iwait=2'b11; dwait=2'b11; ramREN=ramWEN=0; ramaddr=ramstore=0; iload/dload=0.
- A requester is data k (dREN[k]|dWEN[k]) or instr k (iREN[k]).
- Priority in IDLE:
  - Any data request beats any instruction request.
  - Within a class, core rr_ptr wins ties; a lone requester wins regardless of rr_ptr.
- States: IDLE, DGRANT, IGRANT. Grant owner (class, core) is registered on the IDLE->grant edge, so there is 1 cycle of arbitration latency and RAM enables assert the cycle after the request is seen.
- DGRANT core k:
  - dWEN[k]: ramWEN=1, ramstore=dstore[k]. dWEN with dREN set: write wins.
  - dREN[k] with c2c=0: ramREN=1, dload[k]=ramload.
  - dREN[k] with c2c=1: ramWEN=1, ramaddr=daddr[k], ramstore=fwd_data[k], dload[k]=fwd_data[k] (flush plus forward).
  - ramaddr=daddr[k] in all cases.
- IGRANT core k: ramREN=1, ramaddr=iaddr[k], iload[k]=ramload.
- Completion:
  - Owner's wait goes 0 only in the cycle ramstate==ACCESS; word_cnt increments.
  - Non-owner waits stay 1. Wait outputs are 1 whenever the corresponding request is low.
- Hold/release, evaluated on each completion:
  - If word_cnt+1 < BLOCK_WORDS and the owner's request is still high next cycle, keep the grant.
  - Otherwise go to IDLE, clear word_cnt, and set rr_ptr = owner core ^ 1 (the class rotates only on release).
  - Owner dropping its request before completion: back to IDLE next cycle; enables drop; word_cnt cleared; rr_ptr unchanged.
- ERROR: treated as BUSY (no completion); grant held.
- FREE/BUSY: enables held stable, address/data stable.
- Reset mid-transaction: asynchronous return to reset values; no partial completion reported.
- Simultaneous new request and release: new request is only considered from IDLE (1 bubble cycle).

Test Plan:
- Single read: dREN[0]=1, daddr[0]=0x100, RAM returns 0xDEADBEEF after 3 BUSY cycles -> ramREN cycle 1, dwait[0]=0 with dload[0]=0xDEADBEEF on the ACCESS cycle only, then IDLE.
- Priority and fairness: iREN[0], dREN[1], dREN[0] all high at reset -> order is data core0 block (2 words), data core1 block, then instr core0; rr_ptr=1 after first release.
- Block lock: core0 reads 0x200/0x204 while core1 dWEN continuously -> core1 gets no ramWEN until both core0 words complete; core1 write follows after 1 idle cycle.
- Cache-to-cache: dREN[1]=1, c2c=1, fwd_data[1]=0x12345678, daddr[1]=0x300 -> ramWEN=1, ramstore=0x12345678, ramaddr=0x300, dload[1]=0x12345678 at ACCESS, ramREN=0 throughout.
- Abort: owner drops dREN after 1 BUSY cycle -> enables 0 next cycle, dwait never pulses 0, rr_ptr unchanged.
- Reset mid-access: nRST low during BUSY of a write -> ramWEN=0 immediately, all waits 1; after release, pending requests re-arbitrate from rr_ptr=0.
